// File: rtl/deser_trama_32.sv
// Serial-to-parallel frame deserializer: hunts for SYNC, assembles WIDTH bits, VALID/ACK output.
// Optional even-parity check on a trailing bit when PARITY_CHK_EN is defined.
module deser_trama_32 #(
    parameter int                WIDTH  = 32,
    parameter int                SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC   = 8'hA5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENB,
    input  logic             S_IN,
    input  logic             DIR,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             OVF,
    output logic             ERR_PAR
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int FCW = $clog2(SYNC_W + 1);

    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH - 1);
    localparam logic [FCW-1:0] FILL_FULL = FCW'(SYNC_W);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
`ifdef PARITY_CHK_EN
    localparam logic [1:0] PAR  = 2'd2;
`endif

    logic [1:0]        state;
    logic [SYNC_W-1:0] window;
    logic [FCW-1:0]    fillCnt;
    logic [BCW-1:0]    bitCnt;
    logic              dirQ;
    logic [WIDTH-1:0]  shadow;

    logic [SYNC_W-1:0] windowNext;
    logic [FCW-1:0]    fillNext;
    logic              syncHit;
    logic [WIDTH-1:0]  shadowNext;
    logic              lastBit;
    logic              wordDone;
    logic [WIDTH-1:0]  wordOut;
`ifdef PARITY_CHK_EN
    logic              parFail;
`endif

    // Fill count stops at SYNC_W so a full window stays full while hunting.
    function automatic logic [FCW-1:0] satInc(input logic [FCW-1:0] v);
        satInc = (v == FILL_FULL) ? v : v + 1'b1;
    endfunction

`ifdef PARITY_CHK_EN
    function automatic logic evenPar(input logic [WIDTH-1:0] w);
        evenPar = ^w;
    endfunction
`endif

    always_comb begin
        windowNext = {window[SYNC_W-2:0], S_IN};
        fillNext   = satInc(fillCnt);
        syncHit    = (fillNext == FILL_FULL) && (windowNext == SYNC);
        shadowNext = dirQ ? {shadow[WIDTH-2:0], S_IN} : {S_IN, shadow[WIDTH-1:1]};
        lastBit    = (bitCnt == LAST_BIT);
`ifdef PARITY_CHK_EN
        wordOut  = shadow;
        wordDone = 1'b0;
        parFail  = 1'b0;
        if (ENB && state == PAR) begin
            wordDone = (evenPar(shadow) == S_IN);
            parFail  = (evenPar(shadow) != S_IN);
        end
`else
        wordOut  = shadowNext;
        wordDone = ENB && (state == LOAD) && lastBit;
`endif
    end

    // Control: hunt/load sequencing, sync window and counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= HUNT;
            window  <= '0;
            fillCnt <= '0;
            bitCnt  <= '0;
            dirQ    <= 1'b0;
        end else if (ENB) begin
            case (state)
                HUNT: begin
                    window  <= windowNext;
                    fillCnt <= fillNext;
                    if (syncHit) begin
                        state  <= LOAD;
                        bitCnt <= '0;
                        dirQ   <= DIR;
                    end
                end
                LOAD: begin
                    bitCnt <= bitCnt + 1'b1;
                    if (lastBit) begin
                        window  <= '0;
                        fillCnt <= '0;
`ifdef PARITY_CHK_EN
                        state   <= PAR;
`else
                        state   <= HUNT;
`endif
                    end
                end
`ifdef PARITY_CHK_EN
                PAR: state <= HUNT;
`endif
                default: state <= HUNT;
            endcase
        end
    end

    // Data path: shadow register is fully rewritten every frame, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (ENB && state == LOAD) begin
            shadow <= shadowNext;
        end
    end

    // Output word and handshake; a completion with an unconsumed word is dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q     <= '0;
            VALID <= 1'b0;
            OVF   <= 1'b0;
        end else if (wordDone) begin
            if (!VALID || ACK) begin
                Q     <= wordOut;
                VALID <= 1'b1;
            end else begin
                OVF <= 1'b1;
            end
        end else if (VALID && ACK) begin
            VALID <= 1'b0;
        end
    end

`ifdef PARITY_CHK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_PAR <= 1'b0;
        end else begin
            ERR_PAR <= parFail;
        end
    end
`else
    assign ERR_PAR = 1'b0;
`endif

endmodule

// File: tb/tb_deser_trama_32.sv
// Bench for deser_trama_32: directed frames plus random stream against a bit-queue reference model.
// Frames carry a trailing parity bit when PARITY_CHK_EN is defined.
module tb_deser_trama_32;

    logic        CLK;
    logic        RST_N;
    logic        ENB;
    logic        S_IN;
    logic        DIR;
    logic        ACK;
    logic [31:0] Q;
    logic        VALID;
    logic        OVF;
    logic        ERR_PAR;

    int nChecks = 0;
    int nBad    = 0;

    deser_trama_32 dut (
        .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .S_IN(S_IN), .DIR(DIR), .ACK(ACK),
        .Q(Q), .VALID(VALID), .OVF(OVF), .ERR_PAR(ERR_PAR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: queues of received bits, word formed arithmetically.
    int          mState;
    bit          mHist[$];
    bit          mBits[$];
    bit          mDir;
    logic [31:0] mWord;
    logic [31:0] mQ;
    bit          mValid;
    bit          mOvf;
    bit          mErr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mHist.delete();
        mBits.delete();
        mDir   = 1'b0;
        mWord  = '0;
        mQ     = '0;
        mValid = 1'b0;
        mOvf   = 1'b0;
        mErr   = 1'b0;
    endtask

    function automatic logic [31:0] assemble(input bit msbFirst);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) begin
            if (mBits[i]) begin
                if (msbFirst) w = w + (32'd1 << (31 - i));
                else          w = w + (32'd1 << i);
            end
        end
        return w;
    endfunction

    task automatic modelStep(input bit enb, input bit sin, input bit dir, input bit ack);
        bit complete = 1'b0;
        bit errNext  = 1'b0;
        int hv;
        int ones;
        if (enb) begin
            if (mState == 0) begin
                mHist.push_back(sin);
                if (mHist.size() > 8) void'(mHist.pop_front());
                hv = 0;
                foreach (mHist[i]) hv = hv * 2 + int'(mHist[i]);
                if (mHist.size() == 8 && hv == 'hA5) begin
                    mState = 1;
                    mDir   = dir;
                    mBits.delete();
                    mHist.delete();
                end
            end else if (mState == 1) begin
                mBits.push_back(sin);
                if (mBits.size() == 32) begin
                    mWord = assemble(mDir);
`ifdef PARITY_CHK_EN
                    mState = 2;
`else
                    complete = 1'b1;
                    mState   = 0;
`endif
                end
            end else begin
                ones = int'(sin);
                foreach (mBits[i]) ones += int'(mBits[i]);
                if (ones % 2 == 0) complete = 1'b1;
                else               errNext  = 1'b1;
                mState = 0;
            end
        end
        if (complete) begin
            if (!mValid || ack) begin
                mQ     = mWord;
                mValid = 1'b1;
            end else begin
                mOvf = 1'b1;
            end
        end else if (mValid && ack) begin
            mValid = 1'b0;
        end
        mErr = errNext;
    endtask

    task automatic tick(input bit enb, input bit sin, input bit dir, input bit ack);
        ENB  = enb;
        S_IN = sin;
        DIR  = dir;
        ACK  = ack;
        @(posedge CLK);
        #1;
        modelStep(enb, sin, dir, ack);
        chk("q", Q, mQ);
        chk("valid", {31'd0, VALID}, {31'd0, mValid});
        chk("ovf", {31'd0, OVF}, {31'd0, mOvf});
        chk("errpar", {31'd0, ERR_PAR}, {31'd0, mErr});
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        #2;
        modelReset();
        chk("rst_q", Q, 32'd0);
        chk("rst_valid", {31'd0, VALID}, 32'd0);
        chk("rst_ovf", {31'd0, OVF}, 32'd0);
        chk("rst_errpar", {31'd0, ERR_PAR}, 32'd0);
        #2;
        RST_N = 1'b1;
    endtask

    task automatic sendBit(input bit b, input bit dir, input bit gaps, input bit ack, inout int k);
        if (gaps) begin
            k++;
            if (k % 3 == 0) tick(1'b0, 1'($urandom), dir, 1'b0);
        end
        tick(1'b1, b, dir, ack);
    endtask

    task automatic sendByte(input logic [7:0] v, input bit dir);
        int k = 0;
        for (int i = 7; i >= 0; i--) sendBit(v[i], dir, 1'b0, 1'b0, k);
    endtask

    task automatic sendFrame(input logic [31:0] w, input bit dir, input bit gaps,
                             input bit ackLast, input bit badPar);
        int k = 0;
        bit b;
        logic [7:0] s = 8'hA5;
        for (int i = 7; i >= 0; i--) sendBit(s[i], dir, gaps, 1'b0, k);
        for (int i = 0; i < 32; i++) begin
            b = dir ? w[31 - i] : w[i];
`ifdef PARITY_CHK_EN
            sendBit(b, dir, gaps, 1'b0, k);
`else
            sendBit(b, dir, gaps, ackLast && (i == 31), k);
`endif
        end
`ifdef PARITY_CHK_EN
        sendBit((^w) ^ badPar, dir, gaps, ackLast, k);
`else
        if (badPar) k = k + 0;
`endif
    endtask

    initial begin
        int k;
        logic [31:0] w;
        RST_N = 1'b0;
        ENB   = 1'b0;
        S_IN  = 1'b0;
        DIR   = 1'b0;
        ACK   = 1'b0;
        modelReset();
        #3;
        doReset();
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while loading discards the partial word.
        k = 0;
        w = 32'h0F0F3C3C;
        sendByte(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) sendBit(w[31 - i], 1'b1, 1'b0, 1'b0, k);
        doReset();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid_after_rst", {31'd0, VALID}, 32'd0);
        sendFrame(32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_q", Q, 32'hCAFEF00D);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // MSB-first frame.
        sendFrame(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_q", Q, 32'hDEADBEEF);
        chk("t2_valid", {31'd0, VALID}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_valid_cleared", {31'd0, VALID}, 32'd0);

        // LSB-first frame with ENB gaps.
        sendFrame(32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_q", Q, 32'h12345678);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back frames without ACK overflow.
        doReset();
        sendFrame(32'hAAAA5555, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(32'h13579BDF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_q_first", Q, 32'hAAAA5555);
        chk("t4_ovf", {31'd0, OVF}, 32'd1);
        doReset();
        sendFrame(32'hAAAA5555, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(32'h13579BDF, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_q_second", Q, 32'h13579BDF);
        chk("t4_valid", {31'd0, VALID}, 32'd1);
        chk("t4_no_ovf", {31'd0, OVF}, 32'd0);

        // Near-miss noise, then sync pattern embedded in data.
        doReset();
        sendByte(8'h5A, 1'b1);
        sendByte(8'hA4, 1'b1);
        for (int i = 0; i < 34; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_nolock", {31'd0, VALID}, 32'd0);
        sendFrame(32'h00A50000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_q", Q, 32'h00A50000);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHK_EN
        doReset();
        sendFrame(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_good_valid", {31'd0, VALID}, 32'd1);
        chk("t6_good_q", Q, 32'hDEADBEEF);
        doReset();
        sendFrame(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_err", {31'd0, ERR_PAR}, 32'd1);
        chk("t6_bad_valid", {31'd0, VALID}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_err_pulse", {31'd0, ERR_PAR}, 32'd0);
`endif

        // Random stream: noise, random frames, random ACK and gaps.
        doReset();
        for (int f = 0; f < 30; f++) begin
            if (f == 15) doReset();
            for (int n = $urandom_range(0, 6); n > 0; n--)
                tick(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            sendFrame($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
